// File: rtl/sar_adc_sequencer_if.sv
// Control and result bundle of the SAR ADC sequencer. The sequencer side drives
// the DAC, the mux select and the result stream; the environment side drives the rest.
interface sar_adc_sequencer_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              start;
  logic              cont_mode;
  logic [NUM_CH-1:0] ch_mask;
  logic              comp_in;
  logic [WIDTH-1:0]  dac_code;
  logic [CH_W-1:0]   ch_sel;
  logic              busy;
  logic [WIDTH-1:0]  result;
  logic [CH_W-1:0]   result_ch;
  logic              result_valid;
  logic              sweep_done;

  modport master (
    input  start, cont_mode, ch_mask, comp_in,
    output dac_code, ch_sel, busy, result, result_ch, result_valid, sweep_done
  );

  modport slave (
    output start, cont_mode, ch_mask, comp_in,
    input  dac_code, ch_sel, busy, result, result_ch, result_valid, sweep_done
  );
endinterface

// File: rtl/sar_adc_sequencer.sv
// Multi-channel successive-approximation ADC sequencer: MSB-first bit trials on an
// R-2R DAC against a synchronised comparator, averaging 2^AVG_LOG2 conversions per channel.
module sar_adc_sequencer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 CLK100M,
  input  logic                 RESET,
  sar_adc_sequencer_if.master  bus
);
  localparam int unsigned ACC_W     = WIDTH + AVG_LOG2;
  localparam int unsigned CONV_W    = AVG_LOG2 + 1;
  localparam int unsigned BIT_W     = $clog2(WIDTH);
  localparam int unsigned CNT_W     = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned LAST_CONV = (1 << AVG_LOG2) - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_TRIAL, S_SETTLE, S_DECIDE, S_OUTPUT
  } state_t;

  state_t            state_q, state_d;
  logic              comp_meta_q, comp_s_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [WIDTH-1:0]  dac_q, dac_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CONV_W-1:0] conv_q, conv_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [CH_W-1:0]   result_ch_q, result_ch_d;
  logic              rv_q, rv_d;
  logic              sd_q, sd_d;

  logic [NUM_CH-1:0] sel_oh, remaining;
  logic [WIDTH-1:0]  dac_dec;
  logic [ACC_W-1:0]  acc_sum;
  logic              enter_sel;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    logic            found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (m[i] && !found) begin
        idx   = CH_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  always_ff @(posedge CLK100M or negedge RESET) begin
    if (!RESET) begin
      comp_meta_q <= 1'b0;
      comp_s_q    <= 1'b0;
    end else begin
      comp_meta_q <= bus.comp_in;
      comp_s_q    <= comp_meta_q;
    end
  end

  always_ff @(posedge CLK100M or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      ch_sel_q    <= '0;
      dac_q       <= '0;
      acc_q       <= '0;
      conv_q      <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      result_ch_q <= '0;
      rv_q        <= 1'b0;
      sd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ch_sel_q    <= ch_sel_d;
      dac_q       <= dac_d;
      acc_q       <= acc_d;
      conv_q      <= conv_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      rv_q        <= rv_d;
      sd_q        <= sd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ch_sel_d    = ch_sel_q;
    dac_d       = dac_q;
    acc_d       = acc_q;
    conv_d      = conv_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    rv_d        = 1'b0;
    sd_d        = 1'b0;
    enter_sel   = 1'b0;

    sel_oh    = NUM_CH'(1) << ch_sel_q;
    remaining = pending_q & ~sel_oh;
    dac_dec   = dac_q;
    if (!comp_s_q) dac_dec[bit_q] = 1'b0;
    acc_sum   = acc_q + ACC_W'(dac_dec);

    case (state_q)
      S_IDLE: begin
        dac_d = '0;
        if ((bus.start || bus.cont_mode) && (|bus.ch_mask)) begin
          pending_d = bus.ch_mask;
          busy_d    = 1'b1;
          enter_sel = 1'b1;
        end
      end
      S_SELECT: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          state_d = S_TRIAL;
          cnt_d   = '0;
          bit_d   = BIT_W'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRIAL: begin
        dac_d[bit_q] = 1'b1;
        state_d      = S_SETTLE;
        cnt_d        = '0;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = S_DECIDE;
        else                                    cnt_d   = cnt_q + 1'b1;
      end
      S_DECIDE: begin
        dac_d = dac_dec;
        if (bit_q == '0) begin
          acc_d  = acc_sum;
          conv_d = conv_q + 1'b1;
          if (conv_q == CONV_W'(LAST_CONV)) begin
            // Result registers load here so the pulse lines up with the OUTPUT cycle.
            state_d     = S_OUTPUT;
            result_d    = WIDTH'(acc_sum >> AVG_LOG2);
            result_ch_d = ch_sel_q;
            rv_d        = 1'b1;
            sd_d        = (remaining == '0);
            pending_d   = remaining;
          end else begin
            dac_d   = '0;
            state_d = S_TRIAL;
            bit_d   = BIT_W'(WIDTH - 1);
          end
        end else begin
          bit_d   = bit_q - 1'b1;
          state_d = S_TRIAL;
        end
      end
      S_OUTPUT: begin
        if (pending_q != '0) begin
          enter_sel = 1'b1;
        end else if (bus.cont_mode && (|bus.ch_mask)) begin
          pending_d = bus.ch_mask;
          enter_sel = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          dac_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_sel) begin
      state_d  = S_SELECT;
      ch_sel_d = lowest_ch(pending_d);
      dac_d    = '0;
      acc_d    = '0;
      conv_d   = '0;
      cnt_d    = '0;
    end
  end

  assign bus.dac_code     = dac_q;
  assign bus.ch_sel       = ch_sel_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_ch    = result_ch_q;
  assign bus.result_valid = rv_q;
  assign bus.sweep_done   = sd_q;
endmodule

// File: tb/tb_sar_adc_sequencer.sv
// Bench for sar_adc_sequencer: instance A (no averaging) for sweep behaviour, instance B
// (4x averaging) for averaged results and latency; results go through per-instance scoreboards.
module tb_sar_adc_sequencer;
  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] res;
    logic       last;
  } exp_t;

  logic CLK100M = 1'b0;
  logic RESET   = 1'b0;
  always #5 CLK100M = ~CLK100M;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;

  logic [7:0] vin_a [4];
  int         conv_b     = 0;
  logic [7:0] prev_dac_b = 8'h00;

  sar_adc_sequencer_if #(.WIDTH(8), .NUM_CH(4), .CH_W(2)) if_a ();
  sar_adc_sequencer_if #(.WIDTH(8), .NUM_CH(4), .CH_W(2)) if_b ();

  sar_adc_sequencer #(.WIDTH(8), .NUM_CH(4), .SETTLE_CYCLES(16), .AVG_LOG2(0), .CH_W(2)) u_dut_a (
    .CLK100M (CLK100M),
    .RESET   (RESET),
    .bus     (if_a.master)
  );

  sar_adc_sequencer #(.WIDTH(8), .NUM_CH(4), .SETTLE_CYCLES(16), .AVG_LOG2(2), .CH_W(2)) u_dut_b (
    .CLK100M (CLK100M),
    .RESET   (RESET),
    .bus     (if_b.master)
  );

  // Comparator models: A sees a per-channel voltage, B alternates 0x40/0x43 per conversion.
  assign if_a.comp_in = (vin_a[if_a.ch_sel] >= if_a.dac_code);
  assign if_b.comp_in = ((conv_b[0] ? 8'h43 : 8'h40) >= if_b.dac_code);

  always @(posedge CLK100M) begin
    if (prev_dac_b == 8'h00 && if_b.dac_code == 8'h80) conv_b <= conv_b + 1;
    prev_dac_b <= if_b.dac_code;
  end

  always @(negedge CLK100M) begin
    if (RESET && if_a.result_valid) begin
      if (sb_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_a_unexpected: got ch=%0d result=%h, required no result", if_a.result_ch, if_a.result);
      end else begin
        ea = sb_a.pop_front();
        checks++;
        if (if_a.result !== ea.res) begin failures++; $display("FAIL sb_a_result: got %h required %h", if_a.result, ea.res); end
        checks++;
        if (if_a.result_ch !== ea.ch) begin failures++; $display("FAIL sb_a_ch: got %0d required %0d", if_a.result_ch, ea.ch); end
        checks++;
        if (if_a.sweep_done !== ea.last) begin failures++; $display("FAIL sb_a_sweep_done: got %b required %b", if_a.sweep_done, ea.last); end
      end
    end else if (RESET && if_a.sweep_done) begin
      checks++; failures++;
      $display("FAIL sb_a_lone_sweep_done: got 1 required 0");
    end
  end

  always @(negedge CLK100M) begin
    if (RESET && if_b.result_valid) begin
      if (sb_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_b_unexpected: got ch=%0d result=%h, required no result", if_b.result_ch, if_b.result);
      end else begin
        eb = sb_b.pop_front();
        checks++;
        if (if_b.result !== eb.res) begin failures++; $display("FAIL sb_b_result: got %h required %h", if_b.result, eb.res); end
        checks++;
        if (if_b.result_ch !== eb.ch) begin failures++; $display("FAIL sb_b_ch: got %0d required %0d", if_b.result_ch, eb.ch); end
        checks++;
        if (if_b.sweep_done !== eb.last) begin failures++; $display("FAIL sb_b_sweep_done: got %b required %b", if_b.sweep_done, eb.last); end
      end
    end
  end

  task automatic pulse_start(input bit use_b);
    @(negedge CLK100M);
    if (use_b) if_b.start = 1'b1; else if_a.start = 1'b1;
    @(negedge CLK100M);
    if_a.start = 1'b0;
    if_b.start = 1'b0;
  endtask

  task automatic wait_idle(input bit use_b, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK100M);
      if (!(use_b ? if_b.busy : if_a.busy)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK100M);
    checks++;
    if ({if_a.dac_code, if_a.ch_sel, if_a.busy, if_a.result, if_a.result_ch, if_a.result_valid, if_a.sweep_done} !== 23'd0) begin
      failures++; $display("FAIL reset_a_outputs: got dac=%h sel=%0d busy=%b res=%h required all zero", if_a.dac_code, if_a.ch_sel, if_a.busy, if_a.result);
    end
    checks++;
    if ({if_b.dac_code, if_b.ch_sel, if_b.busy, if_b.result, if_b.result_ch, if_b.result_valid, if_b.sweep_done} !== 23'd0) begin
      failures++; $display("FAIL reset_b_outputs: got dac=%h sel=%0d busy=%b res=%h required all zero", if_b.dac_code, if_b.ch_sel, if_b.busy, if_b.result);
    end
    RESET = 1'b1;
    repeat (2) @(negedge CLK100M);
    checks++;
    if (if_a.busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy: got %b required 0", if_a.busy); end
  endtask

  task automatic test_single();
    int n;
    bit ok;
    vin_a[0] = 8'hA5;
    if_a.ch_mask = 4'b0001;
    sb_a.push_back('{ch: 2'd0, res: 8'hA5, last: 1'b1});
    pulse_start(1'b0);
    checks++;
    if (if_a.busy !== 1'b1) begin failures++; $display("FAIL single_busy_rise: got %b required 1", if_a.busy); end
    n = 1;
    while (!if_a.result_valid && n < 400) begin @(negedge CLK100M); n++; end
    checks++;
    if (n != 162) begin failures++; $display("FAIL single_latency: got %0d required 162", n); end
    @(negedge CLK100M);
    checks++;
    if (if_a.busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b required 0", if_a.busy); end
    checks++;
    if (if_a.dac_code !== 8'h00) begin failures++; $display("FAIL single_idle_dac: got %h required 00", if_a.dac_code); end
    wait_idle(1'b0, 10, ok);
  endtask

  task automatic test_boundaries();
    bit         ok;
    logic [7:0] trace[$];
    logic [7:0] prev;
    logic [7:0] want;
    vin_a[0] = 8'h00;
    sb_a.push_back('{ch: 2'd0, res: 8'h00, last: 1'b1});
    pulse_start(1'b0);
    wait_idle(1'b0, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bound_zero_timeout: got busy stuck required idle"); end

    vin_a[0] = 8'hFF;
    sb_a.push_back('{ch: 2'd0, res: 8'hFF, last: 1'b1});
    pulse_start(1'b0);
    prev = 8'h00;
    for (int i = 0; i < 400 && if_a.busy; i++) begin
      if (if_a.dac_code != prev && if_a.dac_code != 8'h00) trace.push_back(if_a.dac_code);
      prev = if_a.dac_code;
      @(negedge CLK100M);
    end
    checks++;
    if (trace.size() != 8) begin failures++; $display("FAIL bound_trial_count: got %0d required 8", trace.size()); end
    for (int k = 0; k < 8 && k < trace.size(); k++) begin
      want = ~(8'hFF >> (k + 1));
      checks++;
      if (trace[k] !== want) begin failures++; $display("FAIL bound_trial_order[%0d]: got %h required %h", k, trace[k], want); end
    end
  endtask

  task automatic test_averaging();
    int n;
    bit ok;
    if_b.ch_mask = 4'b0001;
    sb_b.push_back('{ch: 2'd0, res: 8'h41, last: 1'b1});
    pulse_start(1'b1);
    n = 1;
    while (!if_b.result_valid && n < 800) begin @(negedge CLK100M); n++; end
    checks++;
    if (n != 594) begin failures++; $display("FAIL avg_latency: got %0d required 594", n); end
    wait_idle(1'b1, 10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL avg_idle: got busy stuck required idle"); end
  endtask

  task automatic test_multi();
    logic [3:0] seen;
    bit         ok;
    vin_a[0] = 8'hEE; vin_a[1] = 8'h12; vin_a[2] = 8'hDD; vin_a[3] = 8'h34;
    if_a.ch_mask = 4'b1010;
    sb_a.push_back('{ch: 2'd1, res: 8'h12, last: 1'b0});
    sb_a.push_back('{ch: 2'd3, res: 8'h34, last: 1'b1});
    pulse_start(1'b0);
    seen = 4'b0000;
    for (int i = 0; i < 800 && if_a.busy; i++) begin
      seen[if_a.ch_sel] = 1'b1;
      if (i == 60) begin if_a.start = 1'b1; if_a.ch_mask = 4'b0101; end
      if (i == 61) if_a.start = 1'b0;
      @(negedge CLK100M);
    end
    checks++;
    if (seen !== 4'b1010) begin failures++; $display("FAIL multi_channels_seen: got %b required 1010", seen); end
    repeat (5) @(negedge CLK100M);
    checks++;
    if (if_a.busy !== 1'b0) begin failures++; $display("FAIL multi_start_ignored: got busy %b required 0", if_a.busy); end
    wait_idle(1'b0, 10, ok);
  endtask

  task automatic test_continuous();
    int nres;
    int since;
    bit gap;
    vin_a[0] = 8'h21; vin_a[1] = 8'h9C;
    if_a.ch_mask = 4'b0011;
    for (int s = 0; s < 3; s++) begin
      sb_a.push_back('{ch: 2'd0, res: 8'h21, last: 1'b0});
      sb_a.push_back('{ch: 2'd1, res: 8'h9C, last: 1'b1});
    end
    @(negedge CLK100M);
    if_a.cont_mode = 1'b1;
    @(negedge CLK100M);
    checks++;
    if (if_a.busy !== 1'b1) begin failures++; $display("FAIL cont_autostart: got busy %b required 1", if_a.busy); end
    nres = 0; since = 0; gap = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (if_a.result_valid) nres++;
      if (nres >= 4) since++;
      if (since == 10) if_a.cont_mode = 1'b0;
      if (!if_a.busy) begin
        if (nres < 6) gap = 1'b1;
        break;
      end
      @(negedge CLK100M);
    end
    checks++;
    if (gap) begin failures++; $display("FAIL cont_busy_gap: got busy low after %0d results required 6", nres); end
    checks++;
    if (nres != 6 || if_a.busy !== 1'b0) begin failures++; $display("FAIL cont_result_count: got %0d busy=%b required 6 busy=0", nres, if_a.busy); end
  endtask

  task automatic test_zero_mask();
    bit seen_busy;
    if_a.ch_mask = 4'b0000;
    pulse_start(1'b0);
    seen_busy = 1'b0;
    if_a.cont_mode = 1'b1;
    repeat (6) begin @(negedge CLK100M); if (if_a.busy) seen_busy = 1'b1; end
    if_a.cont_mode = 1'b0;
    checks++;
    if (seen_busy) begin failures++; $display("FAIL zero_mask_busy: got 1 required 0"); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    vin_a[0] = 8'h5A;
    if_a.ch_mask = 4'b0001;
    pulse_start(1'b0);
    repeat (24) @(negedge CLK100M);
    checks++;
    if (if_a.busy !== 1'b1 || if_a.dac_code !== 8'h80) begin
      failures++; $display("FAIL abort_pre_state: got busy=%b dac=%h required busy=1 dac=80", if_a.busy, if_a.dac_code);
    end
    #2 RESET = 1'b0;
    #1;
    checks++;
    if ({if_a.dac_code, if_a.ch_sel, if_a.busy, if_a.result, if_a.result_ch, if_a.result_valid, if_a.sweep_done} !== 23'd0) begin
      failures++; $display("FAIL abort_async_clear: got dac=%h sel=%0d busy=%b res=%h required all zero", if_a.dac_code, if_a.ch_sel, if_a.busy, if_a.result);
    end
    repeat (2) @(negedge CLK100M);
    RESET = 1'b1;
    sb_a.push_back('{ch: 2'd0, res: 8'h5A, last: 1'b1});
    pulse_start(1'b0);
    wait_idle(1'b0, 400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_recovery_timeout: got busy stuck required idle"); end
  endtask

  initial begin
    if_a.start = 1'b0; if_a.cont_mode = 1'b0; if_a.ch_mask = 4'b0000;
    if_b.start = 1'b0; if_b.cont_mode = 1'b0; if_b.ch_mask = 4'b0000;
    for (int i = 0; i < 4; i++) vin_a[i] = 8'h00;

    test_reset();
    test_single();
    test_boundaries();
    test_averaging();
    test_multi();
    test_continuous();
    test_zero_mask();
    test_reset_abort();

    @(negedge CLK100M);
    checks++;
    if (sb_a.size() != 0) begin failures++; $display("FAIL sb_a_leftover: got %0d pending required 0", sb_a.size()); end
    checks++;
    if (sb_b.size() != 0) begin failures++; $display("FAIL sb_b_leftover: got %0d pending required 0", sb_b.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sar_adc_sequencer.md
Name: sar_adc_sequencer

Overview:
- Parametrised multi-channel successive-approximation ADC controller for the 100 MHz display/DAC subsystem.
- Drives the R-2R DAC code and an analogue mux channel select, and reads an external comparator.
- Converts each enabled channel, averaging 2^AVG_LOG2 conversions per channel.
- Streams per-channel results to the display/monitor logic, in single-sweep (manual) or continuous mode.

Parameters:
WIDTH, 8, DAC/result resolution in bits (>=2)
NUM_CH, 4, number of analogue mux channels (>=1)
SETTLE_CYCLES, 16, DAC/mux settling wait in clocks (>=3; covers the 2-flop comparator synchroniser)
AVG_LOG2, 2, log2 of conversions averaged per channel (0 = no averaging)
CH_W, max(1,$clog2(NUM_CH)), derived channel-index width

Ports:
CLK100M  in  1  system clock, 100 MHz
RESET  in  1  asynchronous active-low reset; all state clears while low
start  in  1  single-cycle request for one sweep; used when cont_mode=0
cont_mode  in  1  1 = sweeps repeat back-to-back
ch_mask  in  NUM_CH  enabled channels, bit i = channel i
comp_in  in  1  asynchronous comparator output; 1 when Vin >= V(dac_code)
dac_code  out  WIDTH  R-2R DAC drive
ch_sel  out  CH_W  analogue mux select
busy  out  1  high from sweep start until return to IDLE
result  out  WIDTH  averaged conversion result
result_ch  out  CH_W  channel of result
result_valid  out  1  one-cycle pulse; result/result_ch valid and held until next pulse
sweep_done  out  1  one-cycle pulse, coincident with last channel's result_valid

Behaviour:
- Reset values: dac_code=0, ch_sel=0, busy=0, result=0, result_ch=0, result_valid=0, sweep_done=0, FSM=IDLE, accumulator=0. Reset mid-conversion aborts immediately; no partial result is output.
- comp_in passes through a 2-flop synchroniser (comp_s). comp_s is the only copy of the comparator used by the FSM.
- States: IDLE, SELECT, TRIAL, SETTLE, DECIDE, OUTPUT.
- IDLE:
  - dac_code=0.
  - Sweep starts when (start=1 or cont_mode=1) and ch_mask!=0. On that edge, ch_mask is latched and busy is set.
  - ch_mask==0: start is ignored and busy stays 0.
- SELECT:
  - ch_sel = lowest latched channel not yet converted in this sweep; channels go in ascending order.
  - Clear dac_code, accumulator and conversion count.
  - Hold SELECT for SETTLE_CYCLES+1 cycles (mux settle).
- Per bit i, from WIDTH-1 down to 0 (SETTLE_CYCLES+2 cycles per bit):
  - TRIAL (1 cycle): dac_code[i]=1.
  - SETTLE: wait SETTLE_CYCLES cycles.
  - DECIDE (1 cycle): if comp_s=0, clear bit i; else keep it.
- Conversion end: after bit 0, add the final code to the accumulator (width WIDTH+AVG_LOG2, cannot overflow).
  - Fewer than 2^AVG_LOG2 conversions done: dac_code=0 and go to TRIAL for the MSB.
  - Otherwise go to OUTPUT.
- OUTPUT (1 cycle):
  - result = accumulator >> AVG_LOG2 (truncating); result_ch = ch_sel; result_valid pulses.
  - Last latched channel: sweep_done pulses in the same cycle. Then, if cont_mode=1 and ch_mask!=0, re-latch ch_mask and go to SELECT (busy stays 1); else IDLE, busy=0 and dac_code=0.
  - Not last channel: go to SELECT.
- Per-channel latency, from the SELECT entry cycle to the result_valid cycle inclusive: (SETTLE_CYCLES+1) + 2^AVG_LOG2*WIDTH*(SETTLE_CYCLES+2) + 1. With defaults this is 17+576+1 = 594. busy rises the cycle after start is sampled.
- Mid-sweep events:
  - start while busy: ignored.
  - ch_mask changes mid-sweep: no effect until the next sweep latch.
  - cont_mode cleared mid-sweep: the current sweep completes, then IDLE.
  - cont_mode set while IDLE: a sweep starts next edge without start.
- dac_code is registered and changes only in TRIAL, DECIDE, SELECT entry, conversion restart and IDLE.

Test Plan:
- Comparator model: comp_in = (vin[ch_sel] >= dac_code). Defaults, AVG_LOG2=0, ch_mask=4'b0001, vin0=0xA5, start pulse -> result=0xA5, result_ch=0, result_valid and sweep_done pulse together; busy falls next cycle; dac_code=0 in IDLE.
- Boundaries: vin0=0x00 -> result 0x00; vin0=0xFF -> result 0xFF. Check that bit-trial order is 0x80, 0xC0, ... (MSB first) for 0xFF.
- Averaging: AVG_LOG2=2, vin0 alternating 0x40/0x43 per conversion -> result 0x41 (sum 0x106 >> 2). result_valid appears exactly 594 cycles after SELECT entry (default WIDTH and SETTLE_CYCLES).
- Multi-channel: ch_mask=4'b1010, vin1=0x12, vin3=0x34 -> result_valid (ch1, 0x12), then (ch3, 0x34) with sweep_done. Channels 0 and 2 are never selected. start pulsed mid-sweep is ignored.
- Continuous mode: cont_mode=1, ch_mask=4'b0011 -> repeating ch0, ch1 results with no IDLE gap and busy held high. Clear cont_mode during ch0 -> ch1 still completes, then busy=0. ch_mask=0 with start -> busy stays 0.
- Reset: assert RESET=0 mid-SETTLE -> all outputs zero asynchronously with no result_valid. After release plus start, a normal conversion is produced.
